// File: rtl/dnn_accel_pio_pkg.sv
// dnn_accel_pio_pkg: register map, edge-type encodings and counter sizing for the key input PIO
package dnn_accel_pio_pkg;
    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0] PIO_ADDR_DIR  = 2'd1;
    localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/pio_debounce.sv
// pio_debounce: one input bit through a 2-flop synchroniser and a stability-count debouncer
module pio_debounce
    import dnn_accel_pio_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic RESET_VALUE     = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_in,
    output logic o_d,
    output logic o_edge_rise,
    output logic o_edge_fall
);
    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic          r_s1;
    logic          r_s2;
    logic          r_d;
    logic [CW-1:0] r_cnt;
    logic          w_upd;
    // Edge outputs are combinational so the capture bit sets on the same edge as d.
    assign w_upd = (r_s2 != r_d) && (r_cnt == CNT_LAST);
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s1  <= RESET_VALUE;
            r_s2  <= RESET_VALUE;
            r_d   <= RESET_VALUE;
            r_cnt <= '0;
        end else begin
            r_s1  <= i_in;
            r_s2  <= r_s1;
            r_d   <= w_upd ? r_s2 : r_d;
            r_cnt <= (r_s2 == r_d || w_upd) ? '0 : r_cnt + 1'b1;
        end
    end
    assign o_d         = r_d;
    assign o_edge_rise = w_upd & r_s2;
    assign o_edge_fall = w_upd & ~r_s2;
endmodule

// File: rtl/dnn_accel_system_keys.sv
// dnn_accel_system_keys: Avalon-MM input PIO with debounced keys, edge capture and maskable irq
module dnn_accel_system_keys
    import dnn_accel_pio_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter int               EDGE_TYPE       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    logic [WIDTH-1:0] w_d;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_sel;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_cap;
    logic             w_wr;
    logic             w_unused_wdata;
    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            pio_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .RESET_VALUE    (RESET_VALUE[i])
            ) u_db (
                .clk        (clk),
                .reset_n    (reset_n),
                .i_in       (in_port[i]),
                .o_d        (w_d[i]),
                .o_edge_rise(w_rise[i]),
                .o_edge_fall(w_fall[i])
            );
        end
    endgenerate
    assign w_edge = (EDGE_TYPE == EDGE_RISE) ? w_rise :
                    (EDGE_TYPE == EDGE_FALL) ? w_fall : (w_rise | w_fall);
    assign w_wr   = chipselect && !write_n;
    assign w_clr  = (w_wr && address == PIO_ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
    assign w_unused_wdata = ^writedata;
    // OR-ing the edge after the clear lets a same-cycle edge beat a W1C.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_mask <= '0;
            r_cap  <= '0;
        end else begin
            r_mask <= (w_wr && address == PIO_ADDR_MASK) ? writedata[WIDTH-1:0] : r_mask;
            r_cap  <= (r_cap & ~w_clr) | w_edge;
        end
    end
    assign w_sel = (address == PIO_ADDR_DATA) ? w_d :
                   (address == PIO_ADDR_MASK) ? r_mask :
                   (address == PIO_ADDR_EDGE) ? r_cap : '0;
    assign readdata = 32'(w_sel);
    assign irq      = |(r_cap & r_mask);
endmodule

// File: tb/tb_dnn_accel_system_keys.sv
// tb_dnn_accel_system_keys: directed scoreboard bench; falling-edge DUT plus rise/any siblings on a shared bus
module tb_dnn_accel_system_keys;
    import dnn_accel_pio_pkg::*;
    localparam int S_RD  = 0;
    localparam int S_IRQ = 1;
    localparam int S_RR  = 2;
    localparam int S_RA  = 3;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [3:0]  in_port = 4'hF;
    logic [31:0] rd_f, rd_r, rd_a;
    logic        irq_f, irq_r, irq_a;
    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       nm;
    } chk_t;
    chk_t        q[$];
    chk_t        m_c;
    logic [31:0] m_act;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    dnn_accel_system_keys #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) u_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_f), .irq(irq_f));
    dnn_accel_system_keys #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) u_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_r), .irq(irq_r));
    dnn_accel_system_keys #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) u_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_a), .irq(irq_a));

    // Monitor: drains every expectation queued for the current cycle.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            m_c   = q.pop_front();
            m_act = (m_c.sel == S_RD)  ? rd_f :
                    (m_c.sel == S_IRQ) ? {31'd0, irq_f} :
                    (m_c.sel == S_RR)  ? rd_r : rd_a;
            n_tests++;
            if (m_act !== m_c.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", m_c.nm, m_act, m_c.exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        repeat (n) step();
    endtask

    task automatic push(input int sel, input logic [31:0] exp, input string nm);
        chk_t c;
        c.sel = sel;
        c.exp = exp;
        c.nm  = nm;
        q.push_back(c);
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
        address = a;
        push(S_RD, exp, nm);
        step();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, queue %0d", q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        step();
        push(S_IRQ, 0, "rst_irq_a");
        step();
        push(S_IRQ, 0, "rst_irq_b");
        step();
        reset_n = 1'b1;
        push(S_IRQ, 0, "rel_irq");
        rd(PIO_ADDR_DATA, 32'hF, "rst_data");
        rd(PIO_ADDR_MASK, 32'h0, "rst_mask");
        push(S_RR, 0, "rst_cap_rise");
        push(S_RA, 0, "rst_cap_any");
        push(S_IRQ, 0, "rst_irq_c");
        rd(PIO_ADDR_EDGE, 32'h0, "rst_cap");
        rd(PIO_ADDR_DIR, 32'h0, "dir_zero");
        // Press bit 0: update lands on the sixth edge
        in_port = 4'hE;
        settle(5);
        rd(PIO_ADDR_DATA, 32'hF, "press_data_at5");
        rd(PIO_ADDR_DATA, 32'hE, "press_data_at6");
        push(S_RR, 0, "press_cap_rise");
        push(S_RA, 1, "press_cap_any");
        push(S_IRQ, 0, "press_irq_unmasked");
        rd(PIO_ADDR_EDGE, 32'h1, "press_cap");
        push(S_IRQ, 0, "mask_wr_cycle_irq");
        wr(PIO_ADDR_MASK, 32'h1);
        push(S_IRQ, 1, "mask_irq_next");
        rd(PIO_ADDR_MASK, 32'h1, "mask_read");
        // Release bit 0
        in_port = 4'hF;
        settle(8);
        push(S_RR, 1, "release_cap_rise");
        push(S_RA, 1, "release_cap_any");
        push(S_IRQ, 1, "release_irq");
        rd(PIO_ADDR_EDGE, 32'h1, "release_cap_fall");
        wr(PIO_ADDR_EDGE, 32'hF);
        push(S_IRQ, 0, "clr_irq");
        push(S_RR, 0, "clr_cap_rise");
        push(S_RA, 0, "clr_cap_any");
        rd(PIO_ADDR_EDGE, 32'h0, "clr_cap");
        // Glitch: 3 cycles low rejected, 4 cycles low accepted
        in_port = 4'hB;
        settle(3);
        in_port = 4'hF;
        settle(8);
        rd(PIO_ADDR_DATA, 32'hF, "glitch3_data");
        push(S_RR, 0, "glitch3_cap_rise");
        push(S_RA, 0, "glitch3_cap_any");
        rd(PIO_ADDR_EDGE, 32'h0, "glitch3_cap");
        in_port = 4'hB;
        settle(4);
        in_port = 4'hF;
        settle(10);
        rd(PIO_ADDR_DATA, 32'hF, "glitch4_data");
        push(S_RR, 4, "glitch4_cap_rise");
        push(S_RA, 4, "glitch4_cap_any");
        push(S_IRQ, 0, "glitch4_irq_masked");
        rd(PIO_ADDR_EDGE, 32'h4, "glitch4_cap");
        wr(PIO_ADDR_EDGE, 32'hF);
        // W1C with capture 0x3 and mask 0xF
        in_port = 4'hC;
        settle(8);
        in_port = 4'hF;
        settle(8);
        wr(PIO_ADDR_MASK, 32'hF);
        push(S_IRQ, 1, "w1c_irq_pre");
        push(S_RR, 3, "w1c_cap_rise");
        push(S_RA, 3, "w1c_cap_any");
        rd(PIO_ADDR_EDGE, 32'h3, "w1c_cap_pre");
        wr(PIO_ADDR_EDGE, 32'h1);
        push(S_IRQ, 1, "w1c_irq_after1");
        rd(PIO_ADDR_EDGE, 32'h2, "w1c_cap_after1");
        push(S_IRQ, 1, "w1c_irq_wr2_cycle");
        push(S_RD, 32'h2, "w1c_read_preclear");
        wr(PIO_ADDR_EDGE, 32'h2);
        push(S_IRQ, 0, "w1c_irq_after2");
        rd(PIO_ADDR_EDGE, 32'h0, "w1c_cap_after2");
        // Set wins over a same-cycle W1C
        in_port = 4'hE;
        settle(5);
        wr(PIO_ADDR_EDGE, 32'h1);
        push(S_IRQ, 1, "setwins_irq");
        push(S_RR, 0, "setwins_cap_rise");
        push(S_RA, 1, "setwins_cap_any");
        rd(PIO_ADDR_EDGE, 32'h1, "setwins_cap");
        in_port = 4'hF;
        settle(8);
        wr(PIO_ADDR_EDGE, 32'hF);
        rd(PIO_ADDR_EDGE, 32'h0, "setwins_clr");
        // Reset two cycles into a bit-3 debounce
        in_port = 4'h7;
        settle(4);
        reset_n = 1'b0;
        in_port = 4'hF;
        push(S_IRQ, 0, "midrst_irq_a");
        step();
        push(S_IRQ, 0, "midrst_irq_b");
        step();
        reset_n = 1'b1;
        settle(8);
        rd(PIO_ADDR_DATA, 32'hF, "midrst_data");
        rd(PIO_ADDR_MASK, 32'h0, "midrst_mask");
        push(S_IRQ, 0, "midrst_irq_c");
        push(S_RR, 0, "midrst_cap_rise");
        push(S_RA, 0, "midrst_cap_any");
        rd(PIO_ADDR_EDGE, 32'h0, "midrst_cap");
        // Edge-type sweep on a clean press/release of bit 0
        in_port = 4'hE;
        settle(8);
        push(S_RR, 0, "sweep_press_rise");
        push(S_RA, 1, "sweep_press_any");
        rd(PIO_ADDR_EDGE, 32'h1, "sweep_press_fall");
        wr(PIO_ADDR_EDGE, 32'hF);
        in_port = 4'hF;
        settle(8);
        push(S_RR, 1, "sweep_release_rise");
        push(S_RA, 1, "sweep_release_any");
        rd(PIO_ADDR_EDGE, 32'h0, "sweep_release_fall");
        step();
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d checks left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
